// File: rtl/apb_pkg.sv
// Shared definitions for the APB memory completer.
// Bus width defaults, memory sizing and the phase enum.
package apb_pkg;

    localparam int APB_DATA_W    = 32;
    localparam int APB_ADDR_W    = 32;
    localparam int APB_MEM_DEPTH = 1024;
    localparam int APB_IDX_W     = $clog2(APB_MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } phase_e;

endpackage

// File: rtl/apb_mem_array.sv
// Single-port word array: synchronous write, registered read port.
// Ports: i_clk, i_rst (sync, high), i_we/i_re, i_addr, i_wdata, o_rdata.
module apb_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_we,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    output logic [DATA_WIDTH-1:0]    o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Contents are deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read register only moves on a completed read.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/apb_mem_slave.sv
// APB completer wrapping a word memory with configurable wait states.
// Ports: PCLK, PRESETn (sync, active-high), PSEL/PENABLE/PWRITE/PADDR/PWDATA in; PRDATA/PREADY out.
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH  = APB_DATA_W,
    parameter int ADDR_WIDTH  = APB_ADDR_W,
    parameter int MEM_DEPTH   = APB_MEM_DEPTH,
    parameter int WAIT_STATES = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    logic [3:0] r_wait_cnt;
    phase_e     r_phase;
    logic       w_access;
    logic       w_ready;
    logic       w_unused;

    // Decode straight from PSEL/PENABLE; the phase register is informational.
    assign w_access = PSEL & PENABLE;
    assign w_ready  = w_access & (r_wait_cnt == 4'(WAIT_STATES)) & ~PRESETn;
    assign PREADY   = w_ready;

    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            r_wait_cnt <= '0;
        end else if (!w_access || w_ready) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            r_phase <= IDLE;
        end else begin
            unique case (1'b1)
                !PSEL:           r_phase <= IDLE;
                PSEL & !PENABLE: r_phase <= SETUP;
                default:         r_phase <= ACCESS;
            endcase
        end
    end

    // Upper address bits alias; the phase is kept for observability only.
    assign w_unused = ^{PADDR[ADDR_WIDTH-1:IDX_W], r_phase};

    apb_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH)
    ) u_mem (
        .i_clk   (PCLK),
        .i_rst   (PRESETn),
        .i_we    (w_ready & PWRITE),
        .i_re    (w_ready & ~PWRITE),
        .i_addr  (PADDR[IDX_W-1:0]),
        .i_wdata (PWDATA),
        .o_rdata (PRDATA)
    );

endmodule

// File: tb/tb_apb_mem_slave.sv
// Self-checking bench for apb_mem_slave.
// Two instances: one with no wait states, one with two.
module tb_apb_mem_slave;

    logic        clk;
    logic        rst;
    logic        psel0;
    logic        psel1;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata0;
    logic [31:0] prdata1;
    logic        pready0;
    logic        pready1;

    int tests;
    int fails;

    logic [31:0] mdl [2][1024];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          idle;
    } vec_t;

    vec_t tbl [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    apb_mem_slave #(.WAIT_STATES(0)) dut0 (
        .PCLK(clk), .PRESETn(rst), .PSEL(psel0), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata0), .PREADY(pready0)
    );

    apb_mem_slave #(.WAIT_STATES(2)) dut1 (
        .PCLK(clk), .PRESETn(rst), .PSEL(psel1), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata1), .PREADY(pready1)
    );

    function automatic logic rdy(input int d);
        return (d == 0) ? pready0 : pready1;
    endfunction

    function automatic logic [31:0] rdat(input int d);
        return (d == 0) ? prdata0 : prdata1;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at edge+1; returns at edge+1 after the completing edge,
    // leaving PSEL/PENABLE asserted so callers can chain transfers.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input bit skip_setup,
                        output int waits);
        waits = 0;
        psel0 = (d == 0);
        psel1 = (d == 1);
        pwrite = wr;
        paddr = a;
        pwdata = wd;
        if (!skip_setup) begin
            penable = 1'b0;
            #1;
            check("setup_pready", {31'd0, rdy(d)}, 32'd0);
            @(posedge clk);
            #1;
        end
        penable = 1'b1;
        #1;
        while (!rdy(d) && waits < 40) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (!rdy(d)) begin
            fails++;
            tests++;
            $display("FAIL timeout: pready %b required 1", rdy(d));
        end
        @(posedge clk);
        #1;
        if (wr) mdl[d][a[9:0]] = wd;
    endtask

    task automatic idle(input int n);
        psel0 = 1'b0;
        psel1 = 1'b0;
        penable = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int w;
        bit used [1024];
        logic [31:0] ra [10];
        logic [31:0] a;
        logic [31:0] dv;

        tests = 0;
        fails = 0;
        rst = 1'b1;
        psel0 = 1'b0;
        psel1 = 1'b0;
        penable = 1'b0;
        pwrite = 1'b0;
        paddr = '0;
        pwdata = '0;

        // Reset then idle.
        @(posedge clk);
        #1;
        check("rst_prdata0", prdata0, 32'd0);
        check("rst_prdata1", prdata1, 32'd0);
        check("rst_pready0", {31'd0, pready0}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("idle_prdata", prdata0, 32'd0);
            check("idle_pready", {31'd0, pready0 | pready1}, 32'd0);
        end

        // Directed table: write/read, aliasing overwrite.
        tbl.push_back('{1'b1, 32'h155, 32'h12153524, 2});
        tbl.push_back('{1'b0, 32'h155, 32'h12153524, 1});
        tbl.push_back('{1'b1, 32'h010, 32'hAAAA5555, 0});
        tbl.push_back('{1'b1, 32'h410, 32'hDEADBEEF, 1});
        tbl.push_back('{1'b0, 32'h010, 32'hDEADBEEF, 0});
        tbl.push_back('{1'b0, 32'hFFFF_F410, 32'hDEADBEEF, 1});
        tbl.push_back('{1'b1, 32'h000, 32'h0000_0001, 0});
        tbl.push_back('{1'b0, 32'h400, 32'h0000_0001, 1});
        foreach (tbl[i]) begin
            xfer(0, tbl[i].wr, tbl[i].addr, tbl[i].data, 1'b0, w);
            check("tbl_waits", w, 32'd0);
            if (!tbl[i].wr) check("tbl_read", prdata0, tbl[i].data);
            idle(tbl[i].idle);
        end

        // Write must not disturb the held read value.
        xfer(0, 1'b1, 32'h222, 32'h5A5A5A5A, 1'b0, w);
        check("prdata_hold", prdata0, 32'h00000001);
        // Back-to-back read-after-write, no IDLE between.
        xfer(0, 1'b0, 32'h222, 32'h0, 1'b0, w);
        check("b2b_raw", prdata0, 32'h5A5A5A5A);
        idle(1);

        // Straight to ACCESS with no SETUP cycle.
        xfer(0, 1'b1, 32'h3A0, 32'hCAFEF00D, 1'b1, w);
        idle(1);
        xfer(0, 1'b0, 32'h3A0, 32'h0, 1'b1, w);
        check("nosetup_read", prdata0, 32'hCAFEF00D);
        idle(1);

        // Ten distinct random addresses, write all then read all.
        for (int i = 0; i < 10; i++) begin
            do a = 32'($urandom_range(0, 1023)); while (used[a[9:0]]);
            used[a[9:0]] = 1'b1;
            ra[i] = a;
            xfer(0, 1'b1, a, $urandom, 1'b0, w);
            idle($urandom_range(0, 2));
        end
        for (int i = 0; i < 10; i++) begin
            xfer(0, 1'b0, ra[i], 32'h0, 1'b0, w);
            check("rand_read", prdata0, mdl[0][ra[i][9:0]]);
            idle($urandom_range(0, 1));
        end

        // Wait states: old value, then write 0x3FF, then readback.
        xfer(1, 1'b1, 32'h3FF, 32'h0BADF00D, 1'b0, w);
        idle(1);
        xfer(1, 1'b1, 32'h3FF, 32'h87654321, 1'b0, w);
        check("ws_write_waits", w, 32'd2);
        idle(1);
        xfer(1, 1'b0, 32'h3FF, 32'h0, 1'b0, w);
        check("ws_read_waits", w, 32'd2);
        check("ws_read", prdata1, 32'h87654321);
        idle(1);

        // Randomised traffic on the wait-state instance with aliasing.
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            dv = $urandom;
            xfer(1, 1'b1, a, dv, 1'b0, w);
            idle($urandom_range(0, 1));
            xfer(1, 1'b0, a ^ 32'hFFFF_FC00, 32'h0, 1'b0, w);
            check("ws_rand_read", prdata1, mdl[1][a[9:0]]);
            idle($urandom_range(0, 1));
        end

        // Reset during ACCESS abandons the write.
        xfer(0, 1'b1, 32'h020, 32'h11111111, 1'b0, w);
        idle(1);
        xfer(0, 1'b0, 32'h155, 32'h0, 1'b0, w);
        idle(1);
        psel0 = 1'b1;
        pwrite = 1'b1;
        paddr = 32'h020;
        pwdata = 32'h99999999;
        penable = 1'b0;
        @(posedge clk);
        #1;
        penable = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_mid_pready", {31'd0, pready0}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_mid_prdata", prdata0, 32'd0);
        rst = 1'b0;
        idle(1);
        xfer(0, 1'b0, 32'h020, 32'h0, 1'b0, w);
        check("rst_mid_keep", prdata0, 32'h11111111);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
